// File: rtl/agree_branch_predictor.sv
// Agree predictor: direct-mapped BTB with per-entry bias plus gshare agree PHT.
// Define AGREE_BP_PERF_CNT_EN to build the branch / mispredict counters.
module agree_branch_predictor #(
  parameter int IDX_W     = 6,
  parameter int PHT_IDX_W = 8,
  parameter int GHR_W     = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_pc_f,
  output logic             o_btb_hit,
  output logic             o_pred_taken,
  output logic [31:0]      o_pred_target,
  output logic [GHR_W-1:0] o_pred_ghr,
  input  logic             i_upd_valid,
  input  logic [31:0]      i_upd_pc,
  input  logic             i_upd_taken,
  input  logic [31:0]      i_upd_target,
  input  logic             i_upd_pred_taken,
  input  logic [GHR_W-1:0] i_upd_ghr,
  output logic [31:0]      o_br_cnt,
  output logic [31:0]      o_mispred_cnt
);

  localparam int BTB_N = 1 << IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             btb_vld_q [BTB_N];
  logic             btb_vld_d [BTB_N];
  logic [TAG_W-1:0] btb_tag_q [BTB_N];
  logic [TAG_W-1:0] btb_tag_d [BTB_N];
  logic [31:0]      btb_tgt_q [BTB_N];
  logic [31:0]      btb_tgt_d [BTB_N];
  logic             btb_bias_q [BTB_N];
  logic             btb_bias_d [BTB_N];
  logic [1:0]       pht_q [PHT_N];
  logic [1:0]       pht_d [PHT_N];
  logic [GHR_W-1:0] ghr_q, ghr_d;

  function automatic logic [PHT_IDX_W-1:0] zext(
    input logic [GHR_W-1:0] g
  );
    logic [PHT_IDX_W-1:0] r;
    r = '0;
    r[GHR_W-1:0] = g;
    return r;
  endfunction

  logic [IDX_W-1:0]     p_idx;
  logic [TAG_W-1:0]     p_tag;
  logic [PHT_IDX_W-1:0] p_pidx;
  logic                 p_hit;
  logic                 p_agree;

  assign p_idx  = i_pc_f[IDX_W+1:2];
  assign p_tag  = i_pc_f[31:IDX_W+2];
  assign p_pidx = i_pc_f[PHT_IDX_W+1:2] ^ zext(ghr_q);

  always_comb begin
    p_hit   = btb_vld_q[p_idx] && (btb_tag_q[p_idx] == p_tag);
    p_agree = pht_q[p_pidx][1];
    o_btb_hit     = 1'b0;
    o_pred_taken  = 1'b0;
    o_pred_target = '0;
    o_pred_ghr    = '0;
    if (!i_rst) begin
      o_btb_hit  = p_hit;
      o_pred_ghr = ghr_q;
      if (p_hit) begin
        o_pred_taken  = p_agree ? btb_bias_q[p_idx]
                                : ~btb_bias_q[p_idx];
        o_pred_target = btb_tgt_q[p_idx];
      end
    end
  end

  logic                 upd;
  logic [IDX_W-1:0]     u_idx;
  logic [TAG_W-1:0]     u_tag;
  logic [PHT_IDX_W-1:0] u_pidx;
  logic                 u_hit;

  assign upd    = i_upd_valid & ~i_rst;
  assign u_idx  = i_upd_pc[IDX_W+1:2];
  assign u_tag  = i_upd_pc[31:IDX_W+2];
  assign u_pidx = i_upd_pc[PHT_IDX_W+1:2] ^ zext(i_upd_ghr);
  assign u_hit  = btb_vld_q[u_idx] && (btb_tag_q[u_idx] == u_tag);

  always_comb begin
    btb_vld_d  = btb_vld_q;
    btb_tag_d  = btb_tag_q;
    btb_tgt_d  = btb_tgt_q;
    btb_bias_d = btb_bias_q;
    pht_d      = pht_q;
    ghr_d      = ghr_q;
    if (upd) begin
      ghr_d = {ghr_q[GHR_W-2:0], i_upd_taken};
      if (u_hit) begin
        if (i_upd_taken == btb_bias_q[u_idx]) begin
          if (pht_q[u_pidx] != 2'd3)
            pht_d[u_pidx] = pht_q[u_pidx] + 2'd1;
        end else begin
          if (pht_q[u_pidx] != 2'd0)
            pht_d[u_pidx] = pht_q[u_pidx] - 2'd1;
        end
        if (i_upd_taken)
          btb_tgt_d[u_idx] = i_upd_target;
      end else begin
        // Miss: allocate over any occupant; bias is frozen from here on.
        btb_vld_d[u_idx]  = 1'b1;
        btb_tag_d[u_idx]  = u_tag;
        btb_tgt_d[u_idx]  = i_upd_target;
        btb_bias_d[u_idx] = i_upd_taken;
        pht_d[u_pidx]     = 2'd2;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BTB_N; i++) btb_vld_q[i] <= 1'b0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'd2;
      ghr_q <= '0;
    end else begin
      btb_vld_q <= btb_vld_d;
      pht_q     <= pht_d;
      ghr_q     <= ghr_d;
    end
  end

  // Payload only matters under a valid bit, so it carries no reset.
  always_ff @(posedge i_clk) begin
    btb_tag_q  <= btb_tag_d;
    btb_tgt_q  <= btb_tgt_d;
    btb_bias_q <= btb_bias_d;
  end

`ifdef AGREE_BP_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (i_upd_pred_taken != i_upd_taken)
        mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mis_cnt_q;
`else
  logic unused_perf;
  assign unused_perf   = i_upd_pred_taken;
  assign o_br_cnt      = '0;
  assign o_mispred_cnt = '0;
`endif

  logic unused_pc;
  assign unused_pc = ^{i_pc_f[1:0], i_upd_pc[1:0]};

endmodule

// File: tb/tb_agree_branch_predictor.sv
// Randomized bench for agree_branch_predictor against a behavioural model,
// plus directed literal checks of allocation, agree flip, collision, aliasing.
module tb_agree_branch_predictor;

  localparam int IDX_W     = 6;
  localparam int PHT_IDX_W = 8;
  localparam int GHR_W     = 6;
  localparam int BTB_N     = 1 << IDX_W;
  localparam int PHT_N     = 1 << PHT_IDX_W;
  localparam int GHR_N     = 1 << GHR_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      pc_f;
  logic             btb_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_pred_taken;
  logic [GHR_W-1:0] upd_ghr;
  logic [31:0]      br_cnt;
  logic [31:0]      mispred_cnt;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  agree_branch_predictor #(
    .IDX_W(IDX_W), .PHT_IDX_W(PHT_IDX_W), .GHR_W(GHR_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_pc_f(pc_f),
    .o_btb_hit(btb_hit),
    .o_pred_taken(pred_taken),
    .o_pred_target(pred_target),
    .o_pred_ghr(pred_ghr),
    .i_upd_valid(upd_valid),
    .i_upd_pc(upd_pc),
    .i_upd_taken(upd_taken),
    .i_upd_target(upd_target),
    .i_upd_pred_taken(upd_pred_taken),
    .i_upd_ghr(upd_ghr),
    .o_br_cnt(br_cnt),
    .o_mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model
  bit          m_vld [BTB_N];
  int unsigned m_tag [BTB_N];
  int unsigned m_tgt [BTB_N];
  bit          m_bias [BTB_N];
  int          m_pht [PHT_N];
  int unsigned m_ghr;
  int unsigned m_br;
  int unsigned m_mis;

  function automatic void m_reset();
    for (int i = 0; i < BTB_N; i++) m_vld[i] = 0;
    for (int i = 0; i < PHT_N; i++) m_pht[i] = 2;
    m_ghr = 0;
    m_br  = 0;
    m_mis = 0;
  endfunction

  function automatic int bidx(input int unsigned pc);
    return (pc / 4) % BTB_N;
  endfunction

  function automatic int pidx(input int unsigned pc, input int unsigned g);
    return ((pc / 4) ^ g) % PHT_N;
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_vld[bidx(pc)] && m_tag[bidx(pc)] == pc / (4 * BTB_N);
  endfunction

  function automatic bit m_taken(input int unsigned pc);
    bit agree;
    if (!m_hit(pc)) return 0;
    agree = m_pht[pidx(pc, m_ghr)] >= 2;
    return agree ? m_bias[bidx(pc)] : !m_bias[bidx(pc)];
  endfunction

  function automatic void m_update(
    input int unsigned pc, input bit t, input int unsigned tg,
    input bit pt, input int unsigned g
  );
    int b;
    int p;
    b = bidx(pc);
    p = pidx(pc, g);
    if (m_hit(pc)) begin
      if (t == m_bias[b]) begin
        if (m_pht[p] < 3) m_pht[p]++;
      end else begin
        if (m_pht[p] > 0) m_pht[p]--;
      end
      if (t) m_tgt[b] = tg;
    end else begin
      m_vld[b]  = 1;
      m_tag[b]  = pc / (4 * BTB_N);
      m_tgt[b]  = tg;
      m_bias[b] = t;
      m_pht[p]  = 2;
    end
    m_ghr = (m_ghr * 2 + t) % GHR_N;
    m_br++;
    if (pt != t) m_mis++;
  endfunction

  always @(posedge clk)
    if (!rst && upd_valid)
      m_update(upd_pc, upd_taken, upd_target, upd_pred_taken, upd_ghr);

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] e_hit, e_tk, e_tg, e_gh, e_br, e_mis;
      e_hit = 0; e_tk = 0; e_tg = 0; e_gh = 0; e_br = 0; e_mis = 0;
      if (!rst) begin
        e_hit = {31'd0, m_hit(pc_f)};
        e_tk  = {31'd0, m_taken(pc_f)};
        e_tg  = m_hit(pc_f) ? m_tgt[bidx(pc_f)] : 0;
        e_gh  = m_ghr;
`ifdef AGREE_BP_PERF_CNT_EN
        e_br  = m_br;
        e_mis = m_mis;
`endif
      end
      chk("m_hit", {31'd0, btb_hit}, e_hit);
      chk("m_taken", {31'd0, pred_taken}, e_tk);
      chk("m_target", pred_target, e_tg);
      chk("m_ghr", {{(32-GHR_W){1'b0}}, pred_ghr}, e_gh);
      chk("m_br_cnt", br_cnt, e_br);
      chk("m_mis_cnt", mispred_cnt, e_mis);
    end
  end

  task automatic drive(
    input logic [31:0] pcf, input logic v, input logic [31:0] upc,
    input logic t, input logic [31:0] tg, input logic pt,
    input int unsigned g
  );
    pc_f           = pcf;
    upd_valid      = v;
    upd_pc         = upc;
    upd_taken      = t;
    upd_target     = tg;
    upd_pred_taken = pt;
    upd_ghr        = g[GHR_W-1:0];
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(1, 3)) << (IDX_W + 2)) |
           (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int exp_br;
    int exp_mis;
    rst = 1'b1;
    m_reset();
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_hit", {31'd0, btb_hit}, 0);
    chk("rst_taken", {31'd0, pred_taken}, 0);
    chk("rst_target", pred_target, 0);
    chk("rst_ghr", {26'd0, pred_ghr}, 0);
    next();

    drive(32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
    next();
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alloc_hit", {31'd0, btb_hit}, 1);
    chk("alloc_taken", {31'd0, pred_taken}, 1);
    chk("alloc_target", pred_target, 32'h200);
    chk("alloc_ghr", {26'd0, pred_ghr}, 1);
    next();

    // Seven not-taken updates walk the GHR back to 0, then hit index 0x40.
    for (int k = 0; k < 7; k++) begin
      drive(32'h100, 1, 32'h100, 0, 0, 1, m_ghr);
      next();
    end
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flip_hit", {31'd0, btb_hit}, 1);
    chk("flip_taken", {31'd0, pred_taken}, 0);
    chk("flip_target", pred_target, 32'h200);
    chk("flip_ghr", {26'd0, pred_ghr}, 0);
    next();

    drive(32'h100, 1, 32'h100, 1, 32'h300, 0, 0);
    @(negedge clk);
    chk("coll_same_target", pred_target, 32'h200);
    chk("coll_same_taken", {31'd0, pred_taken}, 0);
    next();
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("coll_next_target", pred_target, 32'h300);
    chk("coll_next_ghr", {26'd0, pred_ghr}, 1);
    next();

    drive(32'h100, 1, 32'h100, 1, 32'h300, 1, m_ghr);
    next();
    drive(32'h100, 1, 32'h100 + (1 << (IDX_W + 2)), 1, 32'h400, 1, m_ghr);
    next();
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alias_old_hit", {31'd0, btb_hit}, 0);
    chk("alias_old_target", pred_target, 0);
    next();
    drive(32'h100 + (1 << (IDX_W + 2)), 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("alias_new_hit", {31'd0, btb_hit}, 1);
    chk("alias_new_target", pred_target, 32'h400);
    chk("alias_new_taken", {31'd0, pred_taken}, 1);
    next();

    // Asynchronous reset between edges, then ten updates with 3 mismatches
    #3 rst = 1'b1;
    m_reset();
    @(negedge clk);
    chk("arst_br", br_cnt, 0);
    chk("arst_hit", {31'd0, btb_hit}, 0);
    next();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic t;
      t = 1'($urandom_range(0, 1));
      drive(rnd_pc(), 1, rnd_pc(), t, $urandom & ~32'h3, t ^ (k < 3), m_ghr);
      next();
    end
    drive(32'h100, 0, 0, 0, 0, 0, 0);
`ifdef AGREE_BP_PERF_CNT_EN
    exp_br = 10;
    exp_mis = 3;
`else
    exp_br = 0;
    exp_mis = 0;
`endif
    @(negedge clk);
    chk("cnt_br", br_cnt, 32'(exp_br));
    chk("cnt_mis", mispred_cnt, 32'(exp_mis));
    next();
    #3 rst = 1'b1;
    m_reset();
    @(negedge clk);
    chk("cnt_rst_br", br_cnt, 0);
    chk("cnt_rst_mis", mispred_cnt, 0);
    next();
    rst = 1'b0;

    for (int k = 0; k < 2000; k++) begin
      int unsigned g;
      g = ($urandom_range(0, 3) != 0) ? m_ghr : $urandom_range(0, GHR_N - 1);
      drive(rnd_pc(), $urandom_range(0, 3) != 0, rnd_pc(),
            1'($urandom_range(0, 1)), $urandom & ~32'h3,
            1'($urandom_range(0, 1)), g);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        m_reset();
        next();
        rst = 1'b0;
      end else begin
        next();
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
